// File: rtl/hdmi_video_timing_if.sv
// -----------------------------------------------------------------------------
// hdmi_video_timing_if
//   Bundles the raster/pixel signals between the HDMI timing generator and
//   its neighbours (upscaler coordinate consumer, TMDS encoder feed).
//
//   Signals:
//     rgb_in      [23:0]  upscaler pixel returned PIPE_LATENCY clocks after hx/hy
//     pattern_sel         colour-bar select (only with HDMI_TIMING_PATTERN_EN)
//     hx, hy      [9:0]   registered raster coordinates
//     frame_start         one-clock pulse while hx==0 && hy==0
//     frame_count [7:0]   completed frames, modulo 256
//     rgb_out     [23:0]  blanked pixel to the encoder
//     de_out              data enable
//     hsync_out           horizontal sync
//     vsync_out           vertical sync
//
//   Modports:
//     master : the timing generator (drives coordinates and the output stream)
//     slave  : the surrounding logic (supplies rgb_in, consumes the rest)
//
//   Optional feature macro: HDMI_TIMING_PATTERN_EN adds pattern_sel.
// -----------------------------------------------------------------------------
interface hdmi_video_timing_if;
    logic [23:0] rgb_in;
`ifdef HDMI_TIMING_PATTERN_EN
    logic        pattern_sel;
`endif
    logic [9:0]  hx;
    logic [9:0]  hy;
    logic        frame_start;
    logic [7:0]  frame_count;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        input  rgb_in,
`ifdef HDMI_TIMING_PATTERN_EN
        input  pattern_sel,
`endif
        output hx,
        output hy,
        output frame_start,
        output frame_count,
        output rgb_out,
        output de_out,
        output hsync_out,
        output vsync_out
    );

    modport slave (
        output rgb_in,
`ifdef HDMI_TIMING_PATTERN_EN
        output pattern_sel,
`endif
        input  hx,
        input  hy,
        input  frame_start,
        input  frame_count,
        input  rgb_out,
        input  de_out,
        input  hsync_out,
        input  vsync_out
    );
endinterface

// File: rtl/hdmi_video_timing.sv
// -----------------------------------------------------------------------------
// hdmi_video_timing
//   Free-running raster generator for the HDMI output path. Issues hx/hy to
//   the upscaler, takes the matching pixel back PIPE_LATENCY clocks later and
//   emits a blanked pixel stream with de/hsync/vsync aligned to it.
//
//   Ports:
//     clk_h  : HDMI pixel clock
//     rst_h  : asynchronous active-high reset
//     vif    : hdmi_video_timing_if.master (rgb_in in; hx, hy, frame_start,
//              frame_count, rgb_out, de_out, hsync_out, vsync_out out)
//
//   Latency: de/hsync/vsync lag the producing hx/hy by PIPE_LATENCY+1 clocks;
//   rgb_out lags rgb_in by one clock.
//
//   Optional feature macro: HDMI_TIMING_PATTERN_EN
//     Adds vif.pattern_sel. When high, active pixels show eight vertical
//     colour bars (white, yellow, cyan, green, magenta, red, blue, black)
//     and rgb_in is ignored.
// -----------------------------------------------------------------------------
module hdmi_video_timing #(
    parameter int OSCREEN_WIDTH  = 720,
    parameter int OSCREEN_HEIGHT = 480,
    parameter int OFRAME_WIDTH   = 858,
    parameter int OFRAME_HEIGHT  = 525,
    parameter int HSYNC_START    = 736,
    parameter int HSYNC_END      = 798,
    parameter int VSYNC_START    = 489,
    parameter int VSYNC_END      = 495,
    parameter int SYNC_POL       = 0,
    parameter int PIPE_LATENCY   = 2
) (
    input  logic                 clk_h,
    input  logic                 rst_h,
    hdmi_video_timing_if.master  vif
);

    localparam logic [9:0] H_LAST      = 10'(OFRAME_WIDTH - 1);
    localparam logic [9:0] V_LAST      = 10'(OFRAME_HEIGHT - 1);
    localparam logic       SYNC_ACTIVE = SYNC_POL[0];
    localparam logic       SYNC_IDLE   = ~SYNC_POL[0];

    // ------------------------------------------------------------------
    // Counter stage
    // ------------------------------------------------------------------
    logic [9:0] hx_reg, hx_next;
    logic [9:0] hy_reg, hy_next;
    logic [7:0] frame_count_reg, frame_count_next;
    logic       frame_start_reg, frame_start_next;
    logic       line_end;
    logic       frame_end;

    always_comb begin
        line_end         = (hx_reg == H_LAST);
        frame_end        = line_end && (hy_reg == V_LAST);
        hx_next          = line_end ? 10'd0 : hx_reg + 10'd1;
        hy_next          = hy_reg;
        if (line_end) begin
            hy_next = (hy_reg == V_LAST) ? 10'd0 : hy_reg + 10'd1;
        end
        frame_count_next = frame_end ? frame_count_reg + 8'd1 : frame_count_reg;
        // Looking at the next state makes the pulse coincide with the
        // registered (0,0) rather than trailing it, and keeps it low while
        // the counters sit at (0,0) under reset.
        frame_start_next = (hx_next == 10'd0) && (hy_next == 10'd0);
    end

    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            hx_reg          <= '0;
            hy_reg          <= '0;
            frame_count_reg <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            hx_reg          <= hx_next;
            hy_reg          <= hy_next;
            frame_count_reg <= frame_count_next;
            frame_start_reg <= frame_start_next;
        end
    end

    // ------------------------------------------------------------------
    // Raw timing decode. Compared at 11 bits so an *_END of 1024 works.
    // vs_r only moves when hy does, which is always at hx==0.
    // ------------------------------------------------------------------
    logic [10:0] hx_ext;
    logic [10:0] hy_ext;
    logic        de_r;
    logic        hs_r;
    logic        vs_r;

    always_comb begin
        hx_ext = {1'b0, hx_reg};
        hy_ext = {1'b0, hy_reg};
        de_r   = (hx_ext < 11'(OSCREEN_WIDTH)) && (hy_ext < 11'(OSCREEN_HEIGHT));
        hs_r   = (hx_ext >= 11'(HSYNC_START)) && (hx_ext < 11'(HSYNC_END));
        vs_r   = (hy_ext >= 11'(VSYNC_START)) && (hy_ext < 11'(VSYNC_END));
    end

    // ------------------------------------------------------------------
    // Delay line: holds "active" flags (not pin levels) so clearing to zero
    // means de low and both syncs idle whatever SYNC_POL is.
    // ------------------------------------------------------------------
    logic [PIPE_LATENCY-1:0] de_pipe_reg;
    logic [PIPE_LATENCY-1:0] hs_pipe_reg;
    logic [PIPE_LATENCY-1:0] vs_pipe_reg;
    logic                    de_d;
    logic                    hs_d;
    logic                    vs_d;

    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            de_pipe_reg <= '0;
            hs_pipe_reg <= '0;
            vs_pipe_reg <= '0;
        end else begin
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                de_pipe_reg[i] <= de_pipe_reg[i-1];
                hs_pipe_reg[i] <= hs_pipe_reg[i-1];
                vs_pipe_reg[i] <= vs_pipe_reg[i-1];
            end
            de_pipe_reg[0] <= de_r;
            hs_pipe_reg[0] <= hs_r;
            vs_pipe_reg[0] <= vs_r;
        end
    end

    assign de_d = de_pipe_reg[PIPE_LATENCY-1];
    assign hs_d = hs_pipe_reg[PIPE_LATENCY-1];
    assign vs_d = vs_pipe_reg[PIPE_LATENCY-1];

`ifdef HDMI_TIMING_PATTERN_EN
    // ------------------------------------------------------------------
    // Colour bars. hx rides the same pipe so the bar edges line up with de.
    // Bar index = hx_d*8/OSCREEN_WIDTH, built from seven constant threshold
    // compares instead of a divider.
    // ------------------------------------------------------------------
    logic [9:0]  hx_pipe_reg [PIPE_LATENCY];
    logic [9:0]  hx_d;
    logic [12:0] hx_x8;
    logic [6:0]  bar_ge;
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                hx_pipe_reg[i] <= '0;
            end
        end else begin
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                hx_pipe_reg[i] <= hx_pipe_reg[i-1];
            end
            hx_pipe_reg[0] <= hx_reg;
        end
    end

    assign hx_d  = hx_pipe_reg[PIPE_LATENCY-1];
    assign hx_x8 = {hx_d, 3'b000};

    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
        assign bar_ge[gi-1] = (hx_x8 >= 13'(gi * OSCREEN_WIDTH));
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
        // Bar order maps to R = ~idx[1], G = ~idx[2], B = ~idx[0].
        bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    end
`endif

    // ------------------------------------------------------------------
    // Output register: pixel and all three timing flags move together.
    // ------------------------------------------------------------------
    logic [23:0] rgb_out_reg, rgb_out_next;
    logic        de_out_reg;
    logic        hsync_out_reg, hsync_out_next;
    logic        vsync_out_reg, vsync_out_next;

    always_comb begin
        rgb_out_next = de_d ? vif.rgb_in : 24'h0;
`ifdef HDMI_TIMING_PATTERN_EN
        if (de_d && vif.pattern_sel) begin
            rgb_out_next = bar_rgb;
        end
`endif
        hsync_out_next = hs_d ? SYNC_ACTIVE : SYNC_IDLE;
        vsync_out_next = vs_d ? SYNC_ACTIVE : SYNC_IDLE;
    end

    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            rgb_out_reg   <= '0;
            de_out_reg    <= 1'b0;
            hsync_out_reg <= SYNC_IDLE;
            vsync_out_reg <= SYNC_IDLE;
        end else begin
            rgb_out_reg   <= rgb_out_next;
            de_out_reg    <= de_d;
            hsync_out_reg <= hsync_out_next;
            vsync_out_reg <= vsync_out_next;
        end
    end

    assign vif.hx          = hx_reg;
    assign vif.hy          = hy_reg;
    assign vif.frame_start = frame_start_reg;
    assign vif.frame_count = frame_count_reg;
    assign vif.rgb_out     = rgb_out_reg;
    assign vif.de_out      = de_out_reg;
    assign vif.hsync_out   = hsync_out_reg;
    assign vif.vsync_out   = vsync_out_reg;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// -----------------------------------------------------------------------------
// tb_hdmi_video_timing
//   Directed bench for hdmi_video_timing. Main instance uses a 72x48 active /
//   86x53 total raster; a second tiny-raster instance (6x3 total, latency 1)
//   covers the 257-frame frame_count wrap in a few thousand clocks.
// -----------------------------------------------------------------------------
module tb_hdmi_video_timing;

    localparam int SW    = 72;
    localparam int SH    = 48;
    localparam int FW    = 86;
    localparam int FH    = 53;
    localparam int HSS   = 75;
    localparam int HSE   = 80;
    localparam int VSS   = 50;
    localparam int VSE   = 51;
    localparam int LAT   = 2;
    localparam int FRAME = FW * FH;   // 4558

    localparam int S_SW = 4;
    localparam int S_SH = 2;
    localparam int S_FW = 6;
    localparam int S_FH = 3;
    localparam int S_FRAME = S_FW * S_FH;   // 18

    logic clk_h;
    logic rst_h;
    logic rst_s;

    hdmi_video_timing_if vif_m ();
    hdmi_video_timing_if vif_s ();

    hdmi_video_timing #(
        .OSCREEN_WIDTH(SW), .OSCREEN_HEIGHT(SH),
        .OFRAME_WIDTH(FW), .OFRAME_HEIGHT(FH),
        .HSYNC_START(HSS), .HSYNC_END(HSE),
        .VSYNC_START(VSS), .VSYNC_END(VSE),
        .SYNC_POL(0), .PIPE_LATENCY(LAT)
    ) u_dut (
        .clk_h (clk_h),
        .rst_h (rst_h),
        .vif   (vif_m)
    );

    hdmi_video_timing #(
        .OSCREEN_WIDTH(S_SW), .OSCREEN_HEIGHT(S_SH),
        .OFRAME_WIDTH(S_FW), .OFRAME_HEIGHT(S_FH),
        .HSYNC_START(4), .HSYNC_END(5),
        .VSYNC_START(2), .VSYNC_END(3),
        .SYNC_POL(0), .PIPE_LATENCY(1)
    ) u_dut_small (
        .clk_h (clk_h),
        .rst_h (rst_s),
        .vif   (vif_s)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    initial begin
        assert (SW < FW && SH < FH && HSS < HSE && HSE <= FW && VSS < VSE &&
                VSE <= FH && FW <= 1024 && FH <= 1024)
            else $fatal(1, "main raster parameters out of range");
        assert (S_SW < S_FW && S_SH < S_FH && S_FW <= 1024 && S_FH <= 1024)
            else $fatal(1, "small raster parameters out of range");
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Bench-side raster position and its recent history (index 0 = now).
    int px = 0;
    int py = 0;
    int hxh [4];
    int hyh [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, then at the falling edge
    // record history and drive rgb_in with the position from two clocks ago.
    task automatic step();
        @(posedge clk_h);
        if (rst_h) begin
            px = 0;
            py = 0;
        end else if (px == FW - 1) begin
            px = 0;
            py = (py == FH - 1) ? 0 : py + 1;
        end else begin
            px = px + 1;
        end
        @(negedge clk_h);
        for (int i = 3; i > 0; i--) begin
            hxh[i] = hxh[i-1];
            hyh[i] = hyh[i-1];
        end
        hxh[0] = px;
        hyh[0] = py;
        vif_m.rgb_in = {8'(hxh[2]), 8'(hyh[2]), 8'h5a};
    endtask

    initial begin
        int fs_first, fs_pulses, cnt_err;
        logic [9:0] hx_at1, hx_at85, hy_at85, hx_at86, hy_at86;
        logic fs_at1, de_at2, de_at3;
        int de_cnt, hs_low, vs_low, hs_falls, vs_falls;
        int h75_at, hs_fall_at, fs_at, de_rise_at, model_err, blank_err;
        logic prev_hs, prev_vs, prev_de, exp_de, exp_hs, exp_vs;
        logic [23:0] exp_rgb;
        logic found;

        for (int i = 0; i < 4; i++) begin
            hxh[i] = 0;
            hyh[i] = 0;
        end
        rst_h = 1'b1;
        rst_s = 1'b1;
        vif_m.rgb_in = 24'hffffff;
        vif_s.rgb_in = 24'h123456;
`ifdef HDMI_TIMING_PATTERN_EN
        vif_m.pattern_sel = 1'b0;
        vif_s.pattern_sel = 1'b0;
`endif

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_hx",          32'(vif_m.hx), 0);
        check("rst_hy",          32'(vif_m.hy), 0);
        check("rst_frame_count", 32'(vif_m.frame_count), 0);
        check("rst_frame_start", 32'(vif_m.frame_start), 0);
        check("rst_rgb_out",     32'(vif_m.rgb_out), 0);
        check("rst_de_out",      32'(vif_m.de_out), 0);
        check("rst_hsync",       32'(vif_m.hsync_out), 1);
        check("rst_vsync",       32'(vif_m.vsync_out), 1);

        // ---------------- first frame ----------------
        rst_h = 1'b0;
        fs_first = 0; fs_pulses = 0; cnt_err = 0;
        hx_at1 = '1; fs_at1 = 1'b1; de_at2 = 1'b1; de_at3 = 1'b0;
        hx_at85 = '1; hy_at85 = '1; hx_at86 = '1; hy_at86 = '1;
        for (int i = 1; i <= FRAME + 2; i++) begin
            step();
            if (i == 1) begin hx_at1 = vif_m.hx; fs_at1 = vif_m.frame_start; end
            if (i == 2) de_at2 = vif_m.de_out;
            if (i == 3) de_at3 = vif_m.de_out;
            if (i == 85) begin hx_at85 = vif_m.hx; hy_at85 = vif_m.hy; end
            if (i == 86) begin hx_at86 = vif_m.hx; hy_at86 = vif_m.hy; end
            if (vif_m.frame_start) begin
                fs_pulses++;
                if (fs_first == 0) fs_first = i;
            end
            if (vif_m.hx !== 10'(px) || vif_m.hy !== 10'(py)) cnt_err++;
        end
        check("first_hx",        32'(hx_at1), 1);
        check("first_fs_low",    32'(fs_at1), 0);
        check("first_de_e2",     32'(de_at2), 0);
        check("first_de_e3",     32'(de_at3), 1);
        check("hx_85",           32'(hx_at85), 85);
        check("hy_at_85",        32'(hy_at85), 0);
        check("hx_wrap",         32'(hx_at86), 0);
        check("hy_step",         32'(hy_at86), 1);
        check("fs_first_clock",  32'(fs_first), FRAME);
        check("fs_pulse_count",  32'(fs_pulses), 1);
        check("counter_track_1", 32'(cnt_err), 0);

        // ---------------- two frames: sync placement and alignment ----------------
        de_cnt = 0; hs_low = 0; vs_low = 0; hs_falls = 0; vs_falls = 0;
        h75_at = -1; hs_fall_at = -1; fs_at = -1; de_rise_at = -1;
        model_err = 0; blank_err = 0; cnt_err = 0;
        prev_hs = vif_m.hsync_out; prev_vs = vif_m.vsync_out; prev_de = vif_m.de_out;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (vif_m.de_out) de_cnt++;
            if (!vif_m.hsync_out) hs_low++;
            if (!vif_m.vsync_out) vs_low++;
            if (prev_hs && !vif_m.hsync_out) begin
                hs_falls++;
                if (h75_at >= 0 && hs_fall_at < 0) hs_fall_at = i;
            end
            if (prev_vs && !vif_m.vsync_out) vs_falls++;
            if (vif_m.hx == 10'(HSS) && h75_at < 0) h75_at = i;
            if (!prev_de && vif_m.de_out && fs_at >= 0 && de_rise_at < 0) de_rise_at = i;
            if (vif_m.frame_start && fs_at < 0) fs_at = i;
            prev_hs = vif_m.hsync_out;
            prev_vs = vif_m.vsync_out;
            prev_de = vif_m.de_out;

            exp_de  = (hxh[3] < SW) && (hyh[3] < SH);
            exp_hs  = !((hxh[3] >= HSS) && (hxh[3] < HSE));
            exp_vs  = !((hyh[3] >= VSS) && (hyh[3] < VSE));
            exp_rgb = exp_de ? {8'(hxh[3]), 8'(hyh[3]), 8'h5a} : 24'h0;
            if (vif_m.de_out !== exp_de || vif_m.hsync_out !== exp_hs ||
                vif_m.vsync_out !== exp_vs || vif_m.rgb_out !== exp_rgb) model_err++;
            if (!vif_m.de_out && vif_m.rgb_out !== 24'h0) blank_err++;
            if (vif_m.hx !== 10'(px) || vif_m.hy !== 10'(py)) cnt_err++;
        end
        check("de_high_clocks",   32'(de_cnt), 2 * SW * SH);
        check("hsync_low_clocks", 32'(hs_low), 2 * FH * (HSE - HSS));
        check("vsync_low_clocks", 32'(vs_low), 2 * FW * (VSE - VSS));
        check("hsync_falls",      32'(hs_falls), 2 * FH);
        check("vsync_falls",      32'(vs_falls), 2);
        check("hsync_delay",      32'(hs_fall_at - h75_at), 3);
        check("de_delay",         32'(de_rise_at - fs_at), 3);
        check("align_model_err",  32'(model_err), 0);
        check("blank_rgb_err",    32'(blank_err), 0);
        check("counter_track_2",  32'(cnt_err), 0);

        // ---------------- async reset mid-line ----------------
        found = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            if (px == 30 && py == 10) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("midreset_reached", 32'(found), 1);
        check("midreset_de_pre",  32'(vif_m.de_out), 1);
        #1 rst_h = 1'b1;
        #1;
        check("midreset_hx",     32'(vif_m.hx), 0);
        check("midreset_hy",     32'(vif_m.hy), 0);
        check("midreset_de",     32'(vif_m.de_out), 0);
        check("midreset_rgb",    32'(vif_m.rgb_out), 0);
        check("midreset_hsync",  32'(vif_m.hsync_out), 1);
        check("midreset_vsync",  32'(vif_m.vsync_out), 1);
        check("midreset_fcount", 32'(vif_m.frame_count), 0);
        #2 rst_h = 1'b0;
        px = 0;
        py = 0;
        for (int i = 0; i < 4; i++) begin
            hxh[i] = 0;
            hyh[i] = 0;
        end
        step();
        check("release_e1_de", 32'(vif_m.de_out), 0);
        check("release_e1_hx", 32'(vif_m.hx), 1);
        step();
        check("release_e2_de", 32'(vif_m.de_out), 0);
        step();
        check("release_e3_de", 32'(vif_m.de_out), 1);
        check("release_e3_hx", 32'(vif_m.hx), 3);
        check("release_e3_hy", 32'(vif_m.hy), 0);

`ifdef HDMI_TIMING_PATTERN_EN
        // ---------------- colour bars ----------------
        begin
            int hits;
            logic [23:0] bar_exp;
            hits = 0;
            vif_m.pattern_sel = 1'b1;
            for (int i = 0; i < 3 * FW; i++) begin
                step();
                if (hyh[3] == 1 && vif_m.de_out) begin
                    bar_exp = 24'hxxxxxx;
                    case (hxh[3])
                        0, 8:   bar_exp = 24'hffffff;
                        9, 17:  bar_exp = 24'hffff00;
                        36:     bar_exp = 24'hff00ff;
                        63, 71: bar_exp = 24'h000000;
                        default: ;
                    endcase
                    if (!$isunknown(bar_exp)) begin
                        hits++;
                        check($sformatf("bar_col_%0d", hxh[3]), 32'(vif_m.rgb_out), 32'(bar_exp));
                    end
                end
            end
            check("bar_columns_seen", 32'(hits), 7);
            vif_m.pattern_sel = 1'b0;
        end
`endif

        // ---------------- frame counter wrap (small raster) ----------------
        begin
            int s_pulses;
            logic de_s1, de_s2;
            logic [23:0] rgb_s2;
            logic [7:0] fc_255, fc_pre0, fc_0, fc_1;
            s_pulses = 0;
            de_s1 = 1'b1; de_s2 = 1'b0; rgb_s2 = '0;
            fc_255 = '0; fc_pre0 = '0; fc_0 = '1; fc_1 = '0;
            rst_s = 1'b0;
            for (int j = 1; j <= 257 * S_FRAME; j++) begin
                step();
                if (j == 1) de_s1 = vif_s.de_out;
                if (j == 2) begin de_s2 = vif_s.de_out; rgb_s2 = vif_s.rgb_out; end
                if (vif_s.frame_start) s_pulses++;
                if (j == 255 * S_FRAME)     fc_255  = vif_s.frame_count;
                if (j == 256 * S_FRAME - 1) fc_pre0 = vif_s.frame_count;
                if (j == 256 * S_FRAME)     fc_0    = vif_s.frame_count;
                if (j == 257 * S_FRAME)     fc_1    = vif_s.frame_count;
            end
            check("small_de_e1",     32'(de_s1), 0);
            check("small_de_e2",     32'(de_s2), 1);
            check("small_rgb_e2",    32'(rgb_s2), 32'h123456);
            check("small_fs_pulses", 32'(s_pulses), 257);
            check("fc_255",          32'(fc_255), 255);
            check("fc_hold_255",     32'(fc_pre0), 255);
            check("fc_wrap_0",       32'(fc_0), 0);
            check("fc_after_1",      32'(fc_1), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
